// File: rtl/irq_nest_ctrl.sv
// Fixed-priority nested interrupt controller: edge/level sources, pending latch,
// nesting stack of served sources and a one-request-at-a-time handshake to the core.
module irq_nest_ctrl #(
  parameter int NUM_IRQ    = 16,
  parameter int NEST_DEPTH = 4,
  parameter int IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_IRQ-1:0]               irq_i,
  input  logic [NUM_IRQ-1:0]               mask_i,
  input  logic [NUM_IRQ-1:0]               edge_mode_i,
  input  logic                             ready_i,
  input  logic                             irq_ret_i,
  output logic                             irq_o,
  output logic [31:0]                      irq_cause_o,
  output logic [NUM_IRQ-1:0]               irq_ret_o,
  output logic [$clog2(NEST_DEPTH+1)-1:0]  nest_level_o,
  output logic                             spurious_o
);

  localparam int LVL_W = $clog2(NEST_DEPTH+1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [IDX_W-1:0]   stack_q [NEST_DEPTH];
  logic [IDX_W-1:0]   stack_d [NEST_DEPTH];
  logic [LVL_W-1:0]   level_q, level_d;
  logic               irq_q, irq_d;
  logic [31:0]        cause_q, cause_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [NUM_IRQ-1:0] ret_q, ret_d;
  logic               spurious_q, spurious_d;

  logic [NUM_IRQ-1:0] rise, act, elig;
  logic [IDX_W-1:0]   top_idx, sel;
  logic [LVL_W-1:0]   lvl_pop;
  logic               full, empty, accept, pop;

  assign full   = (level_q == LVL_W'(NEST_DEPTH));
  assign empty  = (level_q == '0);
  assign rise   = irq_i & ~irq_prev_q;
  assign act    = (edge_mode_i & (pending_q | rise)) | (~edge_mode_i & irq_i);
  assign accept = (state_q == REQ) & ready_i & irq_q;
  assign pop    = irq_ret_i & ~empty;

  always_comb begin
    top_idx = '0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (level_q == LVL_W'(k + 1)) top_idx = stack_q[k];
    end
  end

  // Only strictly higher-priority sources than the current top may nest.
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig[i] = mask_i[i] & act[i] & ~full & (empty | (IDX_W'(i) < top_idx));
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    cause_d    = cause_q;
    req_idx_d  = req_idx_q;
    pending_d  = pending_q;
    stack_d    = stack_q;
    level_d    = level_q;
    ret_d      = '0;
    spurious_d = 1'b0;
    irq_prev_d = irq_i;
    lvl_pop    = level_q;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d   = REQ;
          irq_d     = 1'b1;
          cause_d   = {1'b1, 31'(32'd16 + 32'(sel))};
          req_idx_d = sel;
        end
      end
      REQ: begin
        if (accept) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear on accept first so a rise arriving in the same cycle is not lost.
    if (accept && edge_mode_i[req_idx_q]) pending_d[req_idx_q] = 1'b0;
    pending_d = pending_d | (rise & edge_mode_i);

    if (pop) begin
      lvl_pop = level_q - LVL_W'(1);
      ret_d   = NUM_IRQ'(1) << top_idx;
    end
    spurious_d = irq_ret_i & empty;

    // Pop is applied before push so a simultaneous return and accept keeps the level.
    level_d = lvl_pop;
    if (accept) begin
      for (int k = 0; k < NEST_DEPTH; k++) begin
        if (lvl_pop == LVL_W'(k)) stack_d[k] = req_idx_q;
      end
      level_d = lvl_pop + LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) stack_q[k] <= '0;
      level_q    <= '0;
      irq_q      <= 1'b0;
      cause_q    <= '0;
      req_idx_q  <= '0;
      ret_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
      stack_q    <= stack_d;
      level_q    <= level_d;
      irq_q      <= irq_d;
      cause_q    <= cause_d;
      req_idx_q  <= req_idx_d;
      ret_q      <= ret_d;
      spurious_q <= spurious_d;
    end
  end

  assign irq_o        = irq_q;
  assign irq_cause_o  = cause_q;
  assign irq_ret_o    = ret_q;
  assign nest_level_o = level_q;
  assign spurious_o   = spurious_q;

endmodule
